scnn_psum_drain: RTL

- Downstream stage of the four-buffer accumulate block in the SCNN PE.
- Takes each 64-lane summed partial-sum vector (`added_ops`) and accumulates it across input-channel passes into an internal 64x32 register bank.
- After the pass flagged last, streams the bank to the output-activation RAM writer, OUT_LANES words per beat, over a valid/ready handshake.
- Optional ReLU is applied on the way out.

---
 rtl/scnn_psum_drain.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/scnn_psum_drain.sv
// -----------------------------------------------------------------------------
// scnn_psum_drain
//
// Purpose:
//   Downstream stage of the four-buffer accumulate block in the SCNN PE.
//   Each accepted input beat carries one NUM_OPS-lane vector of summed partial
//   sums (added_ops). These vectors are accumulated, lane by lane, across the
//   input-channel passes of a tile into an internal register bank. When the pass
//   flagged last has been absorbed, the bank is streamed to the output-
//   activation RAM writer OUT_LANES words per beat. An optional ReLU sits on the
//   output path only.
//
// Configuration macro:
//   SCNN_PSUM_RELU_EN - when defined, each out_data lane whose accumulated value
//                       is negative (MSB set) is forced to zero. When undefined,
//                       out_data is the raw accumulator value.
//
// Handshake semantics (both ports):
//   A beat transfers on the rising clk edge where valid and ready are both high.
//   The producer holds its payload stable while valid is high and ready is low.
//   This block never lowers out_valid before the beat transfers, and in_ready
//   does not depend on in_valid.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   added_ops holds a valid vector
//   in_last     in   current input beat is the final pass of the tile
//   added_ops   in   [NUM_OPS][DATA_W] summed partial sums
//   in_ready    out  block accepts a vector this cycle (ACCUM state)
//   out_valid   out  out_data beat valid (DRAIN state)
//   out_ready   in   consumer accepts the beat
//   out_data    out  [OUT_LANES][DATA_W] lanes out_idx*OUT_LANES .. +OUT_LANES-1
//   out_idx     out  beat index within the drain
//   out_last    out  final beat of the drain
//   pass_count  out  passes accepted in the current tile (wraps, informational)
//   busy        out  draining, or a tile is partially accumulated
// -----------------------------------------------------------------------------
module scnn_psum_drain #(
    parameter  int NUM_OPS   = 64,
    parameter  int DATA_W    = 32,
    parameter  int OUT_LANES = 4,
    parameter  int PASS_W    = 8,
    localparam int BEATS     = NUM_OPS / OUT_LANES,
    localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic [NUM_OPS-1:0][DATA_W-1:0]      added_ops,
    output logic                                in_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_LANES-1:0][DATA_W-1:0]    out_data,
    output logic [IDX_W-1:0]                    out_idx,
    output logic                                out_last,
    output logic [PASS_W-1:0]                   pass_count,
    output logic                                busy
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // The bank is stored grouped by output beat so that the drain mux is a
    // plain index by out_idx. Lane w lives at [w / OUT_LANES][w % OUT_LANES],
    // which is the same bit layout as the flat NUM_OPS-lane vector.
    typedef logic [BEATS-1:0][OUT_LANES-1:0][DATA_W-1:0] bank_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    state_t             state_q, state_d;
    bank_t              acc_q, acc_d;
    logic               first_q, first_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PASS_W-1:0]  pass_q, pass_d;

    logic [OUT_LANES-1:0][DATA_W-1:0] beat_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            first_q <= 1'b1;
            idx_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        first_d   = first_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;

        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // The first pass of a tile overwrites whatever the previous
                    // tile left behind instead of adding to it.
                    for (int b = 0; b < BEATS; b++) begin
                        for (int l = 0; l < OUT_LANES; l++) begin
                            acc_d[b][l] = (first_q ? '0 : acc_q[b][l])
                                        + added_ops[b*OUT_LANES + l];
                        end
                    end
                    first_d = 1'b0;
                    pass_d  = pass_q + PASS_W'(1);
                    if (in_last) begin
                        state_d = DRAIN;
                        idx_d   = '0;
                    end
                end
            end

            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Bank contents stay stale; first_q discards them.
                        state_d = ACCUM;
                        idx_d   = '0;
                        first_d = 1'b1;
                        pass_d  = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Output data path: select the beat, then optionally clamp negatives.
    always_comb begin
        beat_sel = acc_q[idx_q];
        out_data = beat_sel;
`ifdef SCNN_PSUM_RELU_EN
        for (int l = 0; l < OUT_LANES; l++) begin
            if (beat_sel[l][DATA_W-1]) begin
                out_data[l] = '0;
            end
        end
`endif
    end

    assign out_idx    = idx_q;
    assign pass_count = pass_q;
    assign busy       = (state_q == DRAIN) || (pass_q != '0);

endmodule
